// File: rtl/ksa_pipe_nbits_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ksa_pkg
// Purpose  : Shared types and elaboration helpers for the pipelined KSA.
// Revision : 1.0 - initial release
// ============================================================================
package ksa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int num_levels(input int width);
        return $clog2(width);
    endfunction

    function automatic int stage_of_level(input int level, input int stages, input int levels);
        return (level * stages) / levels;
    endfunction

    function automatic int first_level(input int stage, input int stages, input int levels);
        int first;
        first = levels;
        for (int j = levels - 1; j >= 0; j--) begin
            if (stage_of_level(j, stages, levels) == stage) first = j;
        end
        return first;
    endfunction

    function automatic int level_count(input int stage, input int stages, input int levels);
        int n;
        n = 0;
        for (int j = 0; j < levels; j++) begin
            if (stage_of_level(j, stages, levels) == stage) n = n + 1;
        end
        return n;
    endfunction

    function automatic bit stages_legal(input int stages, input int levels);
        return (stages >= 1) && (stages <= levels);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_pipe_nbits_prefix_level.sv
`default_nettype none
// ============================================================================
// Module   : ksa_prefix_level
// Purpose  : One combinational Kogge-Stone prefix row of grey/black cells.
// Revision : 1.0 - initial release
// ============================================================================
module ksa_prefix_level
    import ksa_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int SPAN  = 1
) (
    input  gp_t [WIDTH-1:0] gp_in,
    output gp_t [WIDTH-1:0] gp_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < SPAN) begin : g_pass
            assign gp_out[i] = gp_in[i];
        end else if (i < 2 * SPAN) begin : g_grey
            // Group reaches bit 0 after this row, so its propagate is never consumed.
            assign gp_out[i] = '{g: gp_in[i].g | (gp_in[i].p & gp_in[i-SPAN].g),
                                 p: gp_in[i].p};
        end else begin : g_black
            assign gp_out[i] = '{g: gp_in[i].g | (gp_in[i].p & gp_in[i-SPAN].g),
                                 p: gp_in[i].p & gp_in[i-SPAN].p};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ksa_pipe_nbits.sv
`default_nettype none
// ============================================================================
// Module   : ksa_pipe_nbits
// Purpose  : Pipelined Kogge-Stone adder with carry-in and valid/ready flow.
//            Optional subtract mode enabled by macro KSA_PIPE_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ksa_pipe_nbits
    import ksa_pkg::*;
#(
    parameter int WIDTH  = 17,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
`ifdef KSA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    localparam int NUM_LEVELS = num_levels(WIDTH);

    if (WIDTH < 2 || !stages_legal(STAGES, NUM_LEVELS)) begin : g_bad_config
        $error("ksa_pipe_nbits: illegal WIDTH/STAGES combination");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH-1:0] pre_p;
    gp_t  [WIDTH-1:0] pre_gp;

    always_comb begin
`ifdef KSA_PIPE_SUB_EN
        b_eff = sub ? ~in2 : in2;
        c_eff = sub | cin;
`else
        b_eff = in2;
        c_eff = cin;
`endif
        pre_p = in1 ^ b_eff;
        for (int i = 0; i < WIDTH; i++) begin
            pre_gp[i] = '{g: in1[i] & b_eff[i], p: pre_p[i]};
        end
        // Carry-in acts as a generate at bit -1, merged into bit 0.
        pre_gp[0].g = (in1[0] & b_eff[0]) | (pre_p[0] & c_eff);
    end

    logic [STAGES-1:0] valid_q, valid_d, valid_in, adv, load;
    logic              all_full;

    always_comb begin
        all_full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & valid_q[k];
            adv[k]   = out_ready | ~all_full;
        end
        valid_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            valid_in[k] = valid_q[k-1];
        end
        load    = adv & valid_in;
        valid_d = valid_q;
        for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) valid_d[k] = valid_in[k];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[STAGES-1];

    gp_t  [WIDTH-1:0] stg_gp    [STAGES];
    logic [WIDTH-1:0] stg_porig [STAGES];
    logic             stg_cin   [STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FIRST = first_level(s, STAGES, NUM_LEVELS);
        localparam int COUNT = level_count(s, STAGES, NUM_LEVELS);

        gp_t  [WIDTH-1:0] stage_gp;
        logic [WIDTH-1:0] stage_porig;
        logic             stage_cin;

        if (s == 0) begin : g_src_input
            assign stage_gp    = pre_gp;
            assign stage_porig = pre_p;
            assign stage_cin   = c_eff;
        end else begin : g_src_reg
            gp_t  [WIDTH-1:0] gp_d, gp_q;
            logic [WIDTH-1:0] porig_d, porig_q;
            logic             cin_d, cin_q;

            always_comb begin
                gp_d    = gp_q;
                porig_d = porig_q;
                cin_d   = cin_q;
                if (load[s-1]) begin
                    gp_d    = stg_gp[s-1];
                    porig_d = stg_porig[s-1];
                    cin_d   = stg_cin[s-1];
                end
            end

            always_ff @(posedge clk) begin
                gp_q    <= gp_d;
                porig_q <= porig_d;
                cin_q   <= cin_d;
            end

            assign stage_gp    = gp_q;
            assign stage_porig = porig_q;
            assign stage_cin   = cin_q;
        end

        for (genvar j = 0; j < COUNT; j++) begin : g_level
            gp_t [WIDTH-1:0] gp_i, gp_o;
            if (j == 0) begin : g_first
                assign gp_i = stage_gp;
            end else begin : g_next
                assign gp_i = g_level[j-1].gp_o;
            end
            ksa_prefix_level #(
                .WIDTH (WIDTH),
                .SPAN  (1 << (FIRST + j))
            ) u_level (
                .gp_in  (gp_i),
                .gp_out (gp_o)
            );
        end

        assign stg_gp[s]    = g_level[COUNT-1].gp_o;
        assign stg_porig[s] = stage_porig;
        assign stg_cin[s]   = stage_cin;
    end

    logic [WIDTH-1:0] carry, sum;
    logic [WIDTH-1:0] out_d, out_q;
    logic             cout_d, cout_q;
    logic             unused_last_p;

    always_comb begin
        carry[0] = stg_cin[STAGES-1];
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = stg_gp[STAGES-1][i-1].g;
        end
        sum = stg_porig[STAGES-1] ^ carry;
        unused_last_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            unused_last_p = unused_last_p ^ stg_gp[STAGES-1][i].p;
        end
        out_d  = out_q;
        cout_d = cout_q;
        if (load[STAGES-1]) begin
            out_d  = sum;
            cout_d = stg_gp[STAGES-1][WIDTH-1].g;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
        end
    end

    assign out  = out_q;
    assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_ksa_pipe_nbits.sv
`default_nettype none
// ============================================================================
// Module   : tb_ksa_pipe_nbits
// Purpose  : Directed and stall-stress bench for ksa_pipe_nbits (WIDTH=17, STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ksa_pipe_nbits;

    localparam int W = 17;
    localparam int S = 2;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         cin       = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in1       = '0;
    logic [W-1:0] in2       = '0;
`ifdef KSA_PIPE_SUB_EN
    logic         sub       = 1'b0;
`endif
    logic         in_ready, out_valid, cout;
    logic [W-1:0] out;

    int total = 0;
    int bad   = 0;

    logic         smp_in_ready, smp_out_valid, smp_cout;
    logic [W-1:0] smp_out;

    always #5 clk = ~clk;

    ksa_pipe_nbits #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
`ifdef KSA_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout)
    );

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        logic [W-1:0] d;
        d = a - b;
        if (s) model = {(a >= b), d};
        else   model = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Samples mid-cycle, then moves just past the next rising edge.
    task automatic tick();
        @(negedge clk);
        smp_in_ready  = in_ready;
        smp_out_valid = out_valid;
        smp_out       = out;
        smp_cout      = cout;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (smp_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", smp_out_valid); end
        total++; if (smp_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", smp_in_ready); end
        total++; if (smp_out !== '0) begin bad++; $display("FAIL reset_out: got %h want 0", smp_out); end
        total++; if (smp_cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", smp_cout); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [7];
        logic [W-1:0] vb [7];
        logic         vc [7];
        logic [W:0]   ve [7];
        int           lat;
        logic [W:0]   got;
        va = '{17'h1FFFF, 17'h1FFFF, 17'h00000, 17'h0AAAA, 17'h10000, 17'h12345, 17'h00000};
        vb = '{17'h00001, 17'h1FFFF, 17'h00000, 17'h05555, 17'h10000, 17'h0ABCD, 17'h00000};
        vc = '{1'b0,      1'b1,      1'b0,      1'b1,      1'b0,      1'b0,      1'b1};
        ve = '{18'h20000, 18'h3FFFF, 18'h00000, 18'h10000, 18'h20000, 18'h1CF12, 18'h00001};
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            in1 = va[v]; in2 = vb[v]; cin = vc[v]; in_valid = 1'b1;
            tick();
            total++; if (smp_in_ready !== 1'b1) begin bad++; $display("FAIL dir_in_ready[%0d]: got %b want 1", v, smp_in_ready); end
            in_valid = 1'b0;
            lat = -1; got = '0;
            for (int t = 1; t <= S + 3; t++) begin
                tick();
                if (smp_out_valid === 1'b1 && lat < 0) begin
                    lat = t; got = {smp_cout, smp_out};
                end
            end
            total++; if (lat != S) begin bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", v, lat, S); end
            total++; if (got !== ve[v]) begin bad++; $display("FAIL dir_sum[%0d]: got %h want %h", v, got, ve[v]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] e [8];
        logic [W-1:0] a, b;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = W'(k * 17'h02345 + 17'h000F0);
            b = W'(17'h1FFFF - k * 17'h01111);
            e[k] = model(a, b, k[0], 1'b0);
        end
        for (int t = 0; t < 8 + S; t++) begin
            if (t < 8) begin
                in1 = W'(t * 17'h02345 + 17'h000F0);
                in2 = W'(17'h1FFFF - t * 17'h01111);
                cin = t[0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (t < 8) begin
                total++; if (smp_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", t, smp_in_ready); end
            end
            if (t >= S) begin
                total++;
                if (smp_out_valid !== 1'b1 || {smp_cout, smp_out} !== e[t-S]) begin
                    bad++; $display("FAIL b2b_out[%0d]: got v=%b %h want v=1 %h", t - S, smp_out_valid, {smp_cout, smp_out}, e[t-S]);
                end
            end else begin
                total++; if (smp_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_early[%0d]: got %b want 0", t, smp_out_valid); end
            end
        end
        tick();
        total++; if (smp_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail: got %b want 0", smp_out_valid); end
    endtask

    task automatic test_backpressure();
        logic [W:0] q[$];
        logic [W:0] e;
        int nxt, popped;
        nxt = 0; popped = 0;
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            in1 = W'(17'h10000 + nxt * 17'h00101); in2 = W'(17'h0F0F0 + nxt); cin = nxt[0];
            in_valid = 1'b1;
            tick();
            total++; if (smp_in_ready !== (t < S)) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want %b", t, smp_in_ready, (t < S)); end
            if (smp_in_ready) begin
                q.push_back(model(in1, in2, cin, 1'b0));
                nxt++;
            end
            if (t >= S) begin
                total++;
                if (smp_out_valid !== 1'b1 || {smp_cout, smp_out} !== q[0]) begin
                    bad++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", t, smp_out_valid, {smp_cout, smp_out}, q[0]);
                end
            end
        end
        total++; if (nxt != S) begin bad++; $display("FAIL bp_accepted: got %0d want %0d", nxt, S); end
        out_ready = 1'b1;
        for (int t = 0; t < S + 5; t++) begin
            in_valid = (nxt < S + 1);
            in1 = W'(17'h10000 + nxt * 17'h00101); in2 = W'(17'h0F0F0 + nxt); cin = nxt[0];
            tick();
            if (t == 0) begin
                total++; if (smp_in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", smp_in_ready); end
            end
            if (smp_out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra: got %h want none", {smp_cout, smp_out});
                end else begin
                    e = q.pop_front(); popped++;
                    if ({smp_cout, smp_out} !== e) begin bad++; $display("FAIL bp_drain[%0d]: got %h want %h", popped - 1, {smp_cout, smp_out}, e); end
                end
            end
            if (in_valid && smp_in_ready) begin
                q.push_back(model(in1, in2, cin, 1'b0));
                nxt++;
            end
        end
        in_valid = 1'b0;
        total++; if (popped != S + 1) begin bad++; $display("FAIL bp_count: got %0d want %0d", popped, S + 1); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in1 = W'(17'h00F00 + k); in2 = W'(17'h000FF); cin = 1'b1; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        total++; if (out !== '0 || cout !== 1'b0) begin bad++; $display("FAIL mid_out: got %h want 0", {cout, out}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int t = 0; t < S + 3; t++) begin
            tick();
            total++; if (smp_out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d]: got %b want 0", t, smp_out_valid); end
        end
    endtask

    task automatic test_random_stall();
        logic [W:0] q[$];
        logic [W:0] e, pdata;
        logic       pv, pr, s_bit;
        pv = 1'b0; pr = 1'b1; pdata = '0; s_bit = 1'b0;
        for (int t = 0; t < 400 + 12; t++) begin
            if (t < 400) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            in1 = W'($urandom);
            in2 = W'($urandom);
            cin = 1'($urandom_range(0, 1));
`ifdef KSA_PIPE_SUB_EN
            sub   = 1'($urandom_range(0, 1));
            s_bit = sub;
`endif
            tick();
            if (pv && !pr) begin
                total++;
                if (smp_out_valid !== 1'b1 || {smp_cout, smp_out} !== pdata) begin
                    bad++; $display("FAIL rand_hold[%0d]: got v=%b %h want v=1 %h", t, smp_out_valid, {smp_cout, smp_out}, pdata);
                end
            end
            if (smp_out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra[%0d]: got %h want none", t, {smp_cout, smp_out});
                end else begin
                    e = q.pop_front();
                    if ({smp_cout, smp_out} !== e) begin bad++; $display("FAIL rand_sum[%0d]: got %h want %h", t, {smp_cout, smp_out}, e); end
                end
            end
            if (in_valid && smp_in_ready) q.push_back(model(in1, in2, cin, s_bit));
            pv = smp_out_valid; pr = out_ready; pdata = {smp_cout, smp_out};
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_lost: got %0d pending want 0", q.size()); end
`ifdef KSA_PIPE_SUB_EN
        sub = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ksa_pipe_nbits.md
Name: ksa_pipe_nbits

Overview:
- Parametrised, pipelined Kogge-Stone adder; successor to the combinational n-bit KSA.
- Adds carry-in, configurable pipeline depth and valid/ready flow control with backpressure.
- Sits between streaming operand producers and consumers in the arithmetic datapath.
- Sustains one add per cycle.

Parameters:
- WIDTH, 17, operand and sum width in bits (>=2).
- STAGES, 2, number of pipeline register stages; legal range 1..NUM_LEVELS where NUM_LEVELS = $clog2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result this cycle.
- out  output  WIDTH  sum[WIDTH-1:0].
- cout  output  1  carry-out.

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous, active-low.
- Arithmetic: {cout,out} = in1 + in2 + cin, all unsigned, WIDTH+1-bit result, no truncation of the carry.
- Structure:
  - Pre-process: g = in1&in2, p = in1^in2; cin is folded in as generate at bit -1.
  - NUM_LEVELS Kogge-Stone prefix levels with spans 1,2,4,...
  - Post-process: sum = p ^ carry.
- Pipeline partitioning: prefix level j (0..NUM_LEVELS-1) executes in stage floor(j*STAGES/NUM_LEVELS). Pre-processing runs in stage 0. Post-processing runs in stage STAGES-1 and feeds the output register.
- Each stage holds a valid bit plus payload: g, p, original p, and cout-relevant group generate.
- Latency: exactly STAGES cycles from an accepted input (in_valid&in_ready) to out_valid, absent stalls.
- Flow control, stall-with-bubble-collapse:
  - Stage k advances when its valid bit is 0 or stage k+1 advances.
  - The last stage advances when out_valid is 0 or out_ready is 1.
  - in_ready = stage-0 advance condition. It is combinational from out_ready through the valid chain; there is no combinational path from in_valid to in_ready.
- A transfer occurs only on valid&ready. out and cout stay stable while out_valid=1 and out_ready=0.
- in1, in2 and cin are don't-care when in_valid=0; a bubble must not set any valid bit.
- Full pipeline (all STAGES valid bits set) with out_ready=0: in_ready=0 and no data is lost or duplicated.
- Simultaneous out_ready=1 on a full pipeline: in_ready=1 in the same cycle, giving one-in/one-out throughput.
- Reset (asynchronous assert, any time including mid-stall):
  - Clears all valid bits: out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - out=0, cout=0.
  - In-flight operations are discarded.
- Payload registers need no reset except the output register (out/cout reset to 0).

Optional Feature:
- Macro: KSA_PIPE_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1, stage 0 uses ~in2 and forces the effective carry-in to 1, giving out = in1 - in2 mod 2^WIDTH.
  - cout = 1 means no borrow (in1 >= in2).
  - cin is ignored when sub=1.
- When not defined: no sub port, addition only, no extra logic.

Decomposition:
- Package ksa_pkg:
  - Function num_levels(width), wrapping $clog2.
  - Function stage_of_level(level, stages, levels).
  - Typedef gp_t as a packed struct {g,p} used per bit.
  - Function check for legal STAGES, used in an elaboration-time assertion.
- Sub-module ksa_prefix_level (parameters WIDTH, SPAN):
  - Combinational black/grey-cell row.
  - Bits i>=SPAN combine with bit i-SPAN; lower bits pass through.
  - Instantiated NUM_LEVELS times by generate.
- Top holds pre/post-processing, stage registers and handshake logic.

Test Plan:
- WIDTH=17, STAGES=2, in1=0x1FFFF, in2=0x00001, cin=0 -> after 2 cycles out=0x00000, cout=1; cin=1 with in1=in2=0x1FFFF -> out=0x1FFFF, cout=1.
- Streaming: 8 back-to-back inputs with out_ready=1 -> 8 results on consecutive cycles, in order, in_ready never low.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly STAGES accepted then in_ready=0, out held stable; on release, results drain in order with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 2 items in flight -> out_valid=0 immediately (asynchronous), out=0, no stale result after release.
- Randomised: 10000 vectors with random in_valid/out_ready per WIDTH in {8,16,17,32} and every legal STAGES -> scoreboard matches {cout,out}=in1+in2+cin; with KSA_PIPE_SUB_EN, random sub -> matches in1-in2 and no-borrow flag.
